// File: rtl/sdc_pkg.sv
// Shared constants, FSM state encoding and CRC16 step function for the SD SPI write path.
package sdc_pkg;
   localparam logic [7:0] CMD24          = 8'h58;
   localparam logic [7:0] START_TOKEN    = 8'hFE;
   localparam logic [2:0] DRESP_ACCEPTED = 3'b010;

   typedef enum logic [3:0] {
      ST_IDLE, ST_WAIT, ST_CMD, ST_R1, ST_GAP, ST_TOKEN,
      ST_DATA, ST_CRC, ST_DRESP, ST_BUSY, ST_DONE, ST_ERR
   } state_t;

   // CRC-CCITT, poly 0x1021, one input bit per call
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction
endpackage

// File: rtl/sdc_crc16.sv
// Serial CRC16 (CCITT, init 0) over the outgoing data bits.
// Only compiled when SDC_WRITE_CRC16_EN is defined.
`ifdef SDC_WRITE_CRC16_EN
module sdc_crc16
   import sdc_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);
   logic [15:0] crc;

   // Output already folds in the bit of the current cycle so the final
   // value is available on the same edge the last data bit leaves.
   assign o_crc = i_en ? crc16_step(crc, i_bit) : crc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)      crc <= '0;
      else if (i_clr) crc <= '0;
      else if (i_en)  crc <= o_crc;
   end
endmodule
`endif

// File: rtl/sdc_spi_write_block.sv
// SD card (SPI mode) single-block write: CMD24, 512 bytes from a FWFT source, R1/data-response check, busy wait.
// Define SDC_WRITE_CRC16_EN to send a real CRC16 over the data instead of 16'hFFFF.
module sdc_spi_write_block
   import sdc_pkg::*;
#(
   parameter int unsigned WAIT         = 2700,
   parameter logic [31:0] SECTOR       = 32'd16400,
   parameter int unsigned R1_TIMEOUT   = 16,
   parameter int unsigned BUSY_TIMEOUT = 1000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_we,
   input  logic       i_miso,
   input  logic [7:0] i_data,
   output logic       o_rd,
   output logic       o_mosi,
   output logic       o_cs,
   output logic       o_done,
   output logic       o_error,
   output logic [7:0] o_status
);
   state_t      state, nxt;
   logic [47:0] sr;
   logic [7:0]  rx, rx_nxt, status;
   logic [31:0] cnt;
   logic [9:0]  byte_cnt;
   logic        byte_done, err;
   logic [15:0] crc_field;

   assign o_mosi   = sr[47];
   assign o_error  = err;
   assign o_status = status;

`ifdef SDC_WRITE_CRC16_EN
   sdc_crc16 u_crc (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (state == ST_TOKEN),
      .i_en  (state == ST_DATA),
      .i_bit (sr[47]),
      .o_crc (crc_field)
   );
`else
   assign crc_field = 16'hFFFF;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt       = state;
      o_rd      = 1'b0;
      o_done    = 1'b0;
      o_cs      = (state inside {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR});
      rx_nxt    = {rx[6:0], i_miso};
      byte_done = (cnt[2:0] == 3'd7);
      case (state)
         ST_IDLE:  if (i_we) nxt = ST_WAIT;
         ST_WAIT:  if (cnt == WAIT - 1) nxt = ST_CMD;
         ST_CMD:   if (cnt == 32'd47) nxt = ST_R1;
         ST_R1: begin
            if (byte_done) begin
               if (!rx_nxt[7])
                  nxt = (rx_nxt == 8'h00) ? ST_GAP : ST_ERR;
               else if (byte_cnt == 10'(R1_TIMEOUT - 1))
                  nxt = ST_ERR;
            end
         end
         ST_GAP:   if (byte_done) nxt = ST_TOKEN;
         ST_TOKEN: begin
            o_rd = byte_done;
            if (byte_done) nxt = ST_DATA;
         end
         ST_DATA: begin
            if (byte_done) begin
               if (byte_cnt == 10'd511) nxt = ST_CRC;
               else                     o_rd = 1'b1;
            end
         end
         ST_CRC:   if (cnt == 32'd15) nxt = ST_DRESP;
         ST_DRESP: begin
            // data response token has the form xxx0_sss1
            if (byte_done && !rx_nxt[4] && rx_nxt[0])
               nxt = (rx_nxt[3:1] == DRESP_ACCEPTED) ? ST_BUSY : ST_ERR;
         end
         ST_BUSY: begin
            if (i_miso)                          nxt = ST_DONE;
            else if (cnt == BUSY_TIMEOUT - 1)    nxt = ST_ERR;
         end
         ST_DONE, ST_ERR: begin
            o_done = 1'b1;
            nxt    = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sr       <= '1;
         rx       <= '1;
         cnt      <= '0;
         byte_cnt <= '0;
         status   <= 8'hFF;
         err      <= 1'b0;
      end else begin
         rx <= rx_nxt;

         // cnt restarts on every state change, so byte alignment follows state entry
         if (nxt != state || state == ST_IDLE) cnt <= '0;
         else                                  cnt <= cnt + 32'd1;

         if (nxt != state)
            byte_cnt <= '0;
         else if (byte_done && (state == ST_R1 || state == ST_DATA))
            byte_cnt <= byte_cnt + 10'd1;

         if (state == ST_IDLE) begin
            if (i_we) sr <= {CMD24, SECTOR, 8'hFF};
         end else if (o_rd)
            sr <= {i_data, 40'hFF_FFFF_FFFF};
         else if (state == ST_GAP && byte_done)
            sr <= {START_TOKEN, 40'hFF_FFFF_FFFF};
         else if (state == ST_DATA && nxt == ST_CRC)
            sr <= {crc_field, 32'hFFFF_FFFF};
         else if (state != ST_WAIT)
            sr <= {sr[46:0], 1'b1};

         if (state == ST_R1 && byte_done && (!rx_nxt[7] || nxt == ST_ERR))
            status <= rx_nxt;
         if (state == ST_DRESP && nxt != ST_DRESP)
            status <= rx_nxt;

         if (state == ST_IDLE && i_we)         err <= 1'b0;
         else if (nxt == ST_ERR && state != ST_ERR) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sdc_spi_write_block.sv
// Directed bench for sdc_spi_write_block with a cycle-counted SD card model and FWFT byte source.
module tb_sdc_spi_write_block;
   localparam int WAIT_C = 40;

   logic       i_clk = 1'b0;
   logic       i_rst, i_we, i_miso;
   logic [7:0] i_data;
   logic       o_rd, o_mosi, o_cs, o_done, o_error;
   logic [7:0] o_status;

   int checks = 0;
   int errors = 0;

   int   rd_cnt, done_cnt, cs_fall_k, done_k, first_rd_c, gap_err, ncs, abort_k;
   bit   timed_out, aborted;
   logic err_at_done, cs_at_done, ab_cs, ab_rd;
   logic [7:0] st_at_done;
   logic bits [0:8191];

   sdc_spi_write_block #(.WAIT(WAIT_C)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (i_we),
      .i_miso   (i_miso),
      .i_data   (i_data),
      .o_rd     (o_rd),
      .o_mosi   (o_mosi),
      .o_cs     (o_cs),
      .o_done   (o_done),
      .o_error  (o_error),
      .o_status (o_status)
   );

   always #5 i_clk = ~i_clk;

   // c = 1-based count of CS-low cycles; R1 window starts after the 48 command bits
   function automatic logic card_bit(input int c, input int d, input logic [7:0] r1v,
                                     input logic [7:0] drv, input int busy_n);
      int rs, ds;
      rs = 49 + 8 * d;
      ds = 4185 + 8 * d;
      if (c >= rs && c < rs + 8) return r1v[7 - (c - rs)];
      if (c >= ds && c < ds + 8) return drv[7 - (c - ds)];
      if (c >= ds + 8 && c < ds + 8 + busy_n) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [7:0] get_byte(input int i);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[7 - j] = bits[8 * i + j];
      return b;
   endfunction

   // d: FF bytes before R1; abort_rd: assert reset on that o_rd pulse; glitch_k: stray i_we
   task automatic run_txn(input int d, input logic [7:0] r1v, input logic [7:0] drv,
                          input int busy_n, input bit ff_data, input int abort_rd, input int glitch_k);
      int c, idx, last_rd;
      bit rd_pend;
      c = 0; idx = 0; last_rd = -1; rd_pend = 0;
      rd_cnt = 0; done_cnt = 0; cs_fall_k = -1; done_k = -1; first_rd_c = -1;
      gap_err = 0; aborted = 0; abort_k = -1;
      err_at_done = 1'bx; cs_at_done = 1'bx; st_at_done = 8'hxx; ab_cs = 1'bx; ab_rd = 1'bx;
      foreach (bits[i]) bits[i] = 1'bx;
      @(negedge i_clk);
      i_we = 1'b1;
      for (int k = 0; k < 12000; k++) begin
         @(negedge i_clk);
         i_we = (k == glitch_k);
         if (rd_pend) begin idx++; rd_pend = 0; end
         i_data = ff_data ? 8'hFF : 8'(idx);
         if (!o_cs) begin
            c++;
            if (cs_fall_k < 0) cs_fall_k = k;
            if (c <= 8192) bits[c - 1] = o_mosi;
         end
         i_miso = o_cs ? 1'b1 : card_bit(c, d, r1v, drv, busy_n);
         if (o_rd) begin
            if (rd_cnt == 0) first_rd_c = c;
            else if (k - last_rd != 8) gap_err++;
            last_rd = k;
            rd_cnt++;
            rd_pend = 1;
            if (rd_cnt == abort_rd) begin
               i_rst = 1'b1;
               #1;
               ab_cs = o_cs; ab_rd = o_rd; aborted = 1; abort_k = k;
            end
         end
         if (o_done) begin
            done_cnt++;
            if (done_k < 0) begin
               done_k = k; err_at_done = o_error; st_at_done = o_status; cs_at_done = o_cs;
            end
         end
         if (done_k >= 0 && k >= done_k + 4) break;
         if (aborted && k >= abort_k + 20) break;
      end
      ncs = c;
      timed_out = !aborted && done_k < 0;
      if (aborted) begin
         @(negedge i_clk);
         i_rst = 1'b0;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_we = 1'b0; i_miso = 1'b1; i_data = 8'h00;
      #23;
      checks++; if (o_cs !== 1'b1)      begin errors++; $display("FAIL reset_cs: got %b expected 1", o_cs); end
      checks++; if (o_mosi !== 1'b1)    begin errors++; $display("FAIL reset_mosi: got %b expected 1", o_mosi); end
      checks++; if (o_rd !== 1'b0)      begin errors++; $display("FAIL reset_rd: got %b expected 0", o_rd); end
      checks++; if (o_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
      checks++; if (o_error !== 1'b0)   begin errors++; $display("FAIL reset_error: got %b expected 0", o_error); end
      checks++; if (o_status !== 8'hFF) begin errors++; $display("FAIL reset_status: got %h expected ff", o_status); end
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_r1_error();
      run_txn(0, 8'h04, 8'hE5, 0, 1'b0, -1, -1);
      checks++; if (timed_out)          begin errors++; $display("FAIL r1err_timeout: no o_done within budget"); end
      checks++; if (rd_cnt != 0)        begin errors++; $display("FAIL r1err_rd: got %0d pulses expected 0", rd_cnt); end
      checks++; if (ncs != 56)          begin errors++; $display("FAIL r1err_cs_cycles: got %0d expected 56", ncs); end
      checks++; if (done_cnt != 1)      begin errors++; $display("FAIL r1err_done_cnt: got %0d expected 1", done_cnt); end
      checks++; if (done_k != WAIT_C + 56) begin errors++; $display("FAIL r1err_done_time: got %0d expected %0d", done_k, WAIT_C + 56); end
      checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL r1err_error: got %b expected 1", err_at_done); end
      checks++; if (st_at_done !== 8'h04) begin errors++; $display("FAIL r1err_status: got %h expected 04", st_at_done); end
      checks++; if (cs_at_done !== 1'b1)  begin errors++; $display("FAIL r1err_cs: got %b expected 1", cs_at_done); end
   endtask

   task automatic test_nominal();
      int bad;
      logic [47:0] cmd;
      logic [31:0] mid;
      run_txn(1, 8'h00, 8'hE5, 200, 1'b0, -1, 1000);
      checks++; if (timed_out) begin errors++; $display("FAIL nom_timeout: no o_done within budget"); end
      checks++; if (cs_fall_k != WAIT_C) begin errors++; $display("FAIL nom_cs_fall: got %0d expected %0d", cs_fall_k, WAIT_C); end
      cmd = {get_byte(0), get_byte(1), get_byte(2), get_byte(3), get_byte(4), get_byte(5)};
      checks++; if (cmd !== 48'h58_0000_4010_FF) begin errors++; $display("FAIL nom_cmd: got %h expected 5800004010ff", cmd); end
      mid = {get_byte(6), get_byte(7), get_byte(8), get_byte(9)};
      checks++; if (mid !== 32'hFFFF_FFFE) begin errors++; $display("FAIL nom_poll_gap_token: got %h expected fffffffe", mid); end
      bad = 0;
      for (int i = 0; i < 512; i++) if (get_byte(10 + i) !== 8'(i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL nom_data: got %0d bad bytes expected 0", bad); end
`ifndef SDC_WRITE_CRC16_EN
      checks++; if ({get_byte(522), get_byte(523)} !== 16'hFFFF) begin errors++; $display("FAIL nom_crc: got %h%h expected ffff", get_byte(522), get_byte(523)); end
`endif
      checks++; if (get_byte(524) !== 8'hFF) begin errors++; $display("FAIL nom_dresp_mosi: got %h expected ff", get_byte(524)); end
      checks++; if (rd_cnt != 512)     begin errors++; $display("FAIL nom_rd_cnt: got %0d expected 512", rd_cnt); end
      checks++; if (gap_err != 0)      begin errors++; $display("FAIL nom_rd_spacing: got %0d bad gaps expected 0", gap_err); end
      checks++; if (first_rd_c != 80)  begin errors++; $display("FAIL nom_first_rd: got %0d expected 80", first_rd_c); end
      checks++; if (done_cnt != 1)     begin errors++; $display("FAIL nom_done_cnt: got %0d expected 1", done_cnt); end
      checks++; if (done_k != WAIT_C + 4401) begin errors++; $display("FAIL nom_done_time: got %0d expected %0d", done_k, WAIT_C + 4401); end
      checks++; if (err_at_done !== 1'b0)  begin errors++; $display("FAIL nom_error: got %b expected 0", err_at_done); end
      checks++; if (st_at_done !== 8'hE5)  begin errors++; $display("FAIL nom_status: got %h expected e5", st_at_done); end
      checks++; if (cs_at_done !== 1'b1)   begin errors++; $display("FAIL nom_cs: got %b expected 1", cs_at_done); end
   endtask

   task automatic test_r1_timeout();
      run_txn(100000, 8'hFF, 8'hFF, 0, 1'b0, -1, -1);
      checks++; if (timed_out)            begin errors++; $display("FAIL r1to_timeout: no o_done within budget"); end
      checks++; if (ncs != 176)           begin errors++; $display("FAIL r1to_cs_cycles: got %0d expected 176", ncs); end
      checks++; if (done_k != WAIT_C + 176) begin errors++; $display("FAIL r1to_done_time: got %0d expected %0d", done_k, WAIT_C + 176); end
      checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL r1to_error: got %b expected 1", err_at_done); end
      checks++; if (st_at_done !== 8'hFF) begin errors++; $display("FAIL r1to_status: got %h expected ff", st_at_done); end
      checks++; if (rd_cnt != 0)          begin errors++; $display("FAIL r1to_rd: got %0d expected 0", rd_cnt); end
   endtask

   task automatic test_data_reject();
      run_txn(0, 8'h00, 8'h0B, 50, 1'b0, -1, -1);
      checks++; if (timed_out)            begin errors++; $display("FAIL drej_timeout: no o_done within budget"); end
      checks++; if (done_k != WAIT_C + 4192) begin errors++; $display("FAIL drej_done_time: got %0d expected %0d", done_k, WAIT_C + 4192); end
      checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL drej_error: got %b expected 1", err_at_done); end
      checks++; if (st_at_done !== 8'h0B) begin errors++; $display("FAIL drej_status: got %h expected 0b", st_at_done); end
      checks++; if (rd_cnt != 512)        begin errors++; $display("FAIL drej_rd_cnt: got %0d expected 512", rd_cnt); end
      checks++; if (ncs != 4192)          begin errors++; $display("FAIL drej_cs_cycles: got %0d expected 4192", ncs); end
   endtask

   task automatic test_crc_field();
      logic [15:0] crc, exp_crc;
`ifdef SDC_WRITE_CRC16_EN
      exp_crc = 16'h7FA1;
`else
      exp_crc = 16'hFFFF;
`endif
      run_txn(0, 8'h00, 8'hE5, 10, 1'b1, -1, -1);
      crc = {get_byte(521), get_byte(522)};
      checks++; if (crc !== exp_crc)      begin errors++; $display("FAIL crc_field: got %h expected %h", crc, exp_crc); end
      checks++; if (done_k != WAIT_C + 4203) begin errors++; $display("FAIL crc_done_time: got %0d expected %0d", done_k, WAIT_C + 4203); end
      checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL crc_error: got %b expected 0", err_at_done); end
   endtask

   task automatic test_reset_mid_data();
      int bad;
      run_txn(0, 8'h00, 8'hE5, 20, 1'b0, 100, -1);
      checks++; if (!aborted)         begin errors++; $display("FAIL abort_reached: got %0d rd pulses before abort expected 100", rd_cnt); end
      checks++; if (ab_cs !== 1'b1)   begin errors++; $display("FAIL abort_cs: got %b expected 1", ab_cs); end
      checks++; if (ab_rd !== 1'b0)   begin errors++; $display("FAIL abort_rd: got %b expected 0", ab_rd); end
      checks++; if (done_cnt != 0)    begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
      run_txn(0, 8'h00, 8'hE5, 20, 1'b0, -1, -1);
      bad = 0;
      for (int i = 0; i < 512; i++) if (get_byte(9 + i) !== 8'(i)) bad++;
      checks++; if (bad != 0)          begin errors++; $display("FAIL restart_data: got %0d bad bytes expected 0", bad); end
      checks++; if (rd_cnt != 512)     begin errors++; $display("FAIL restart_rd_cnt: got %0d expected 512", rd_cnt); end
      checks++; if (done_k != WAIT_C + 4213) begin errors++; $display("FAIL restart_done_time: got %0d expected %0d", done_k, WAIT_C + 4213); end
      checks++; if (err_at_done !== 1'b0)  begin errors++; $display("FAIL restart_error: got %b expected 0", err_at_done); end
      checks++; if (st_at_done !== 8'hE5)  begin errors++; $display("FAIL restart_status: got %h expected e5", st_at_done); end
   endtask

   initial begin
      test_reset();
      test_r1_error();
      test_nominal();
      test_r1_timeout();
      test_data_reject();
      test_crc_field();
      test_reset_mid_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
